// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encoding, BCD limits and timing defaults for the clock counter
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STOP    = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_t;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    localparam int DEFAULT_TICKS_PER_SEC = 50_000_000;

    // Mode_Key walks the modes in a fixed ring.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN:     return STOP;
            STOP:    return SET_MIN;
            SET_MIN: return SET_SEC;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_counter_module_if.sv
// rtl/clock_counter_module_if.sv - key inputs and BCD time outputs of the clock counter
interface clock_counter_module_if;

    logic       Mode_Key;
    logic       Inc_Key;
    logic       Clr;
    logic [3:0] SecL;
    logic [3:0] SecH;
    logic [3:0] MinL;
    logic [3:0] MinH;
    logic       Sec_Tick;
    logic       Hour_Wrap;
    logic [1:0] Mode;

    modport master (
        output Mode_Key, Inc_Key, Clr,
        input  SecL, SecH, MinL, MinH, Sec_Tick, Hour_Wrap, Mode
    );

    modport slave (
        input  Mode_Key, Inc_Key, Clr,
        output SecL, SecH, MinL, MinH, Sec_Tick, Hour_Wrap, Mode
    );

endinterface

// File: rtl/bcd_mod60_counter.sv
// rtl/bcd_mod60_counter.sv - two-digit BCD counter 00..59 with synchronous clear and carry-out
module bcd_mod60_counter
    import clock_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_lo,
    output logic [3:0] o_hi,
    output logic       o_carry_out
);

    logic [3:0] r_lo;
    logic [3:0] r_hi;
    logic       w_at_max;

    assign w_at_max    = (r_lo == UNITS_MAX) && (r_hi == TENS_MAX);
    // Carry is combinational so the next pair can step on the same edge.
    assign o_carry_out = i_inc && w_at_max;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_lo <= 4'd0;
            r_hi <= 4'd0;
        end else if (i_inc) begin
            if (r_lo == UNITS_MAX) begin
                r_lo <= 4'd0;
                r_hi <= (r_hi == TENS_MAX) ? 4'd0 : r_hi + 4'd1;
            end else begin
                r_lo <= r_lo + 4'd1;
            end
        end
    end

    assign o_lo = r_lo;
    assign o_hi = r_hi;

endmodule

// File: rtl/clock_counter_module.sv
// rtl/clock_counter_module.sv - 1 Hz prescaler, run/stop/set mode FSM and BCD mm:ss count
module clock_counter_module
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
    parameter int PRE_W         = 26
) (
    input  logic                  CLK,
    input  logic                  RST,
    clock_counter_module_if.slave bus
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    mode_t            r_mode;
    mode_t            w_mode_next;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_next;
    logic             r_sec_tick;
    logic             r_hour_wrap;

    logic             w_counting;
    logic             w_tick;
    logic             w_set_inc;
    logic             w_sec_inc;
    logic             w_min_inc;
    logic             w_sec_carry;
    logic             w_min_carry;
    logic             w_digit_clr;
    logic [3:0]       w_sec_lo;
    logic [3:0]       w_sec_hi;
    logic [3:0]       w_min_lo;
    logic [3:0]       w_min_hi;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (bus.Mode_Key) begin
            w_mode_next = next_mode(r_mode);
        end
    end

    // Clr and a mode change both pre-empt the tick and park the prescaler at 0.
    always_comb begin
        w_counting = (r_mode == RUN) && !bus.Mode_Key && !bus.Clr;
        w_tick     = w_counting && (r_pre == PRE_LAST);
        w_pre_next = '0;
        if (w_counting && (r_pre != PRE_LAST)) begin
            w_pre_next = r_pre + PRE_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pre       <= '0;
            r_sec_tick  <= 1'b0;
            r_hour_wrap <= 1'b0;
        end else begin
            r_pre       <= w_pre_next;
            r_sec_tick  <= w_tick;
            r_hour_wrap <= w_tick && w_min_carry;
        end
    end

    // Set-mode increments never cross between pairs; only a RUN tick chains seconds into minutes.
    always_comb begin
        w_set_inc   = bus.Inc_Key && !bus.Mode_Key && !bus.Clr;
        w_sec_inc   = w_tick || ((r_mode == SET_SEC) && w_set_inc);
        w_min_inc   = (w_tick && w_sec_carry) || ((r_mode == SET_MIN) && w_set_inc);
        w_digit_clr = RST || bus.Clr;
    end

    bcd_mod60_counter u_seconds (
        .i_clk       (CLK),
        .i_clr       (w_digit_clr),
        .i_inc       (w_sec_inc),
        .o_lo        (w_sec_lo),
        .o_hi        (w_sec_hi),
        .o_carry_out (w_sec_carry)
    );

    bcd_mod60_counter u_minutes (
        .i_clk       (CLK),
        .i_clr       (w_digit_clr),
        .i_inc       (w_min_inc),
        .o_lo        (w_min_lo),
        .o_hi        (w_min_hi),
        .o_carry_out (w_min_carry)
    );

    assign bus.SecL      = w_sec_lo;
    assign bus.SecH      = w_sec_hi;
    assign bus.MinL      = w_min_lo;
    assign bus.MinH      = w_min_hi;
    assign bus.Sec_Tick  = r_sec_tick;
    assign bus.Hour_Wrap = r_hour_wrap;
    assign bus.Mode      = r_mode;

endmodule
